// File: rtl/trap_sequencer_pkg.sv
// Shared types, CSR addresses and mstatus field helpers for the trap sequencer.
//   XLEN / CSR_AW      : data and CSR address widths
//   CSR_*              : machine-mode CSR addresses touched by the sequencer
//   MSTATUS_*          : mstatus bit positions (MIE, MPIE, MPP)
//   trap_info_t        : exception payload latched on accept
//   align4 / mstatus_* : masking helpers used by the FSM datapath
package trap_sequencer_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [CSR_AW-1:0] csr_addr_t;

  localparam csr_addr_t CSR_MSTATUS = CSR_AW'(12'h300);
  localparam csr_addr_t CSR_MTVEC   = CSR_AW'(12'h305);
  localparam csr_addr_t CSR_MEPC    = CSR_AW'(12'h341);
  localparam csr_addr_t CSR_MCAUSE  = CSR_AW'(12'h342);
  localparam csr_addr_t CSR_MTVAL   = CSR_AW'(12'h343);

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Exception payload captured in the accept cycle.
  typedef struct packed {
    xlen_t cause;
    xlen_t pc;
    xlen_t tval;
  } trap_info_t;

  // Clear the two low bits of a PC / vector base.
  function automatic xlen_t align4(input xlen_t v);
    return v & ~XLEN'(3);
  endfunction

  // mstatus after trap entry: MPIE<=MIE, MIE<=0, MPP<=M; other bits kept.
  function automatic xlen_t mstatus_trap_entry(input xlen_t ms);
    xlen_t r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus after mret: MIE<=MPIE, MPIE<=1, MPP<=M (M-mode only); other bits kept.
  function automatic xlen_t mstatus_mret(input xlen_t ms);
    xlen_t r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle of pipeline-side and regfile-side signals around the trap sequencer.
//   pipeline -> seq : trap_req/cause/pc/tval, mret_req, pipe_r_addr, pipe_w_*
//   seq -> pipeline : pipe_r_val, busy, redirect_valid, redirect_pc
//   seq <-> regfile : csr_r_addr/csr_r_val (read port), csr_w_*/w_enable (write port)
// modport slave is the sequencer; modport master is its environment.
interface trap_sequencer_if;
  import trap_sequencer_pkg::*;

  logic      trap_req;
  xlen_t     trap_cause;
  xlen_t     trap_pc;
  xlen_t     trap_tval;
  logic      mret_req;

  csr_addr_t pipe_r_addr;
  xlen_t     pipe_r_val;
  csr_addr_t pipe_w_addr;
  xlen_t     pipe_w_val;
  logic      pipe_w_enable;

  csr_addr_t csr_r_addr;
  xlen_t     csr_r_val;
  csr_addr_t csr_w_addr;
  xlen_t     csr_w_val;
  logic      w_enable;

  logic      busy;
  logic      redirect_valid;
  xlen_t     redirect_pc;

  modport slave (
    input  trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    input  pipe_r_addr, pipe_w_addr, pipe_w_val, pipe_w_enable,
    input  csr_r_val,
    output pipe_r_val,
    output csr_r_addr, csr_w_addr, csr_w_val, w_enable,
    output busy, redirect_valid, redirect_pc
  );

  modport master (
    output trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    output pipe_r_addr, pipe_w_addr, pipe_w_val, pipe_w_enable,
    output csr_r_val,
    input  pipe_r_val,
    input  csr_r_addr, csr_w_addr, csr_w_val, w_enable,
    input  busy, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer owning the CSR regfile's read and write ports.
// Idle: pipeline CSR accesses pass straight through. On an exception it writes
// mepc, mcause, mtval, mstatus in turn and redirects fetch to mtvec; on mret it
// rewrites mstatus and redirects fetch to mepc.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : trap_sequencer_if.slave (pipeline, regfile and redirect signals)
module trap_sequencer
  import trap_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  trap_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    T_EPC    = 4'd1,
    T_CAUSE  = 4'd2,
    T_TVAL   = 4'd3,
    T_STATUS = 4'd4,
    T_JUMP   = 4'd5,
    M_RD     = 4'd6,
    M_WR     = 4'd7,
    M_JUMP   = 4'd8
  } state_e;

  state_e     state_q, state_d;
  trap_info_t info_q;
  xlen_t      ms_q;
  xlen_t      redirect_pc_q;
  logic       busy_q;
  logic       redirect_valid_q;

  csr_addr_t  csr_r_addr_c;
  csr_addr_t  csr_w_addr_c;
  xlen_t      csr_w_val_c;
  logic       w_enable_c;
  logic       ms_load_c;
  logic       target_load_c;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, regfile port muxing and latch-enable decode.
  always_comb begin
    state_d       = state_q;
    csr_r_addr_c  = '0;
    csr_w_addr_c  = '0;
    csr_w_val_c   = '0;
    w_enable_c    = 1'b0;
    ms_load_c     = 1'b0;
    target_load_c = 1'b0;

    case (state_q)
      IDLE: begin
        csr_r_addr_c = bus.pipe_r_addr;
        csr_w_addr_c = bus.pipe_w_addr;
        csr_w_val_c  = bus.pipe_w_val;
        w_enable_c   = bus.pipe_w_enable;
        // The excepting/mret instruction's own CSR write is dropped.
        if (bus.trap_req) begin
          w_enable_c = 1'b0;
          state_d    = T_EPC;
        end else if (bus.mret_req) begin
          w_enable_c = 1'b0;
          state_d    = M_RD;
        end
      end

      // mstatus is read here and written in T_STATUS so no cycle both reads
      // and writes the same CSR through the forwarding regfile.
      T_EPC: begin
        csr_w_addr_c = CSR_MEPC;
        csr_w_val_c  = align4(info_q.pc);
        w_enable_c   = 1'b1;
        csr_r_addr_c = CSR_MSTATUS;
        ms_load_c    = 1'b1;
        state_d      = T_CAUSE;
      end

      T_CAUSE: begin
        csr_w_addr_c = CSR_MCAUSE;
        csr_w_val_c  = info_q.cause;
        w_enable_c   = 1'b1;
        state_d      = T_TVAL;
      end

      T_TVAL: begin
        csr_w_addr_c = CSR_MTVAL;
        csr_w_val_c  = info_q.tval;
        w_enable_c   = 1'b1;
        state_d      = T_STATUS;
      end

      T_STATUS: begin
        csr_w_addr_c  = CSR_MSTATUS;
        csr_w_val_c   = mstatus_trap_entry(ms_q);
        w_enable_c    = 1'b1;
        csr_r_addr_c  = CSR_MTVEC;
        target_load_c = 1'b1;
        state_d       = T_JUMP;
      end

      T_JUMP: begin
        state_d = IDLE;
      end

      M_RD: begin
        csr_r_addr_c = CSR_MSTATUS;
        ms_load_c    = 1'b1;
        state_d      = M_WR;
      end

      M_WR: begin
        csr_w_addr_c  = CSR_MSTATUS;
        csr_w_val_c   = mstatus_mret(ms_q);
        w_enable_c    = 1'b1;
        csr_r_addr_c  = CSR_MEPC;
        target_load_c = 1'b1;
        state_d       = M_JUMP;
      end

      M_JUMP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payload latches and registered status/redirect outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      info_q           <= '0;
      ms_q             <= '0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      busy_q           <= (state_d != IDLE);
      redirect_valid_q <= (state_d == T_JUMP) || (state_d == M_JUMP);
      if ((state_q == IDLE) && bus.trap_req) begin
        info_q <= '{cause: bus.trap_cause, pc: bus.trap_pc, tval: bus.trap_tval};
      end
      if (ms_load_c) begin
        ms_q <= bus.csr_r_val;
      end
      // mtvec base (both modes) or mepc, already aligned for the redirect.
      if (target_load_c) begin
        redirect_pc_q <= align4(bus.csr_r_val);
      end
    end
  end

  assign bus.csr_r_addr     = csr_r_addr_c;
  assign bus.csr_w_addr     = csr_w_addr_c;
  assign bus.csr_w_val      = csr_w_val_c;
  assign bus.w_enable       = w_enable_c;
  assign bus.pipe_r_val     = bus.csr_r_val;
  assign bus.busy           = busy_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

  // The sequencer itself must never read and write one CSR in the same cycle.
  a_no_same_addr_rw: assert property (@(posedge clock) disable iff (!reset)
    !((state_q != IDLE) && w_enable_c && (csr_w_addr_c == csr_r_addr_c)));

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a forwarding CSR regfile model, a write log,
// a pass-through vector table and hand-written trap/mret/reset sequences.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  trap_sequencer_if bus ();

  trap_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // CSR regfile model: combinational read with same-cycle write forwarding.
  logic [31:0] mem [0:4095];

  always_comb begin
    if (bus.w_enable && (bus.csr_w_addr == bus.csr_r_addr)) bus.csr_r_val = bus.csr_w_val;
    else bus.csr_r_val = mem[bus.csr_r_addr];
  end

  always @(posedge clock) begin
    if (bus.w_enable) mem[bus.csr_w_addr] <= bus.csr_w_val;
  end

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] val;
  } wr_t;

  wr_t wlog[$];

  always @(negedge clock) begin
    if (bus.w_enable) wlog.push_back('{addr: bus.csr_w_addr, val: bus.csr_w_val});
  end

  typedef struct {
    logic [11:0] r_addr;
    logic [11:0] w_addr;
    logic [31:0] w_val;
    logic        w_en;
    logic [31:0] exp_r_val;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_pipe();
    bus.trap_req      = 1'b0;
    bus.mret_req      = 1'b0;
    bus.pipe_w_enable = 1'b0;
    bus.pipe_w_addr   = '0;
    bus.pipe_w_val    = '0;
  endtask

  // Pass-through write; starts and ends just after a rising edge.
  task automatic csr_write(input logic [11:0] a, input logic [31:0] v);
    bus.pipe_w_addr   = a;
    bus.pipe_w_val    = v;
    bus.pipe_w_enable = 1'b1;
    @(posedge clock); #1;
    clear_pipe();
  endtask

  // Steps n cycles after the accept edge, counting busy and redirect cycles.
  task automatic observe(input int n, input int inject_mret, output int busy_cnt,
                         output int redir_cnt, output int redir_cyc, output logic [31:0] redir_pc);
    busy_cnt  = 0;
    redir_cnt = 0;
    redir_cyc = -1;
    redir_pc  = '0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock); #1;
      clear_pipe();
      if (i == inject_mret) bus.mret_req = 1'b1;
      @(negedge clock);
      if (bus.busy) busy_cnt++;
      if (bus.redirect_valid) begin
        redir_cnt++;
        redir_cyc = i;
        redir_pc  = bus.redirect_pc;
      end
    end
    @(posedge clock); #1;
    clear_pipe();
  endtask

  task automatic check_wlog(input string tag, input int n, input logic [11:0] ea [4],
                            input logic [31:0] ev [4]);
    check({tag, "_nwrites"}, 32'(wlog.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wlog.size()) begin
        check($sformatf("%s_wr%0d_addr", tag, i), 32'(wlog[i].addr), 32'(ea[i]));
        check($sformatf("%s_wr%0d_val", tag, i), wlog[i].val, ev[i]);
      end else begin
        check($sformatf("%s_wr%0d_missing", tag, i), 32'(0), 32'(1));
      end
    end
  endtask

  task automatic start_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    bus.trap_tval  = tval;
    bus.trap_req   = 1'b1;
  endtask

  task automatic read_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.pipe_r_addr = a;
    #1;
    check(name, bus.pipe_r_val, exp);
  endtask

  initial begin : main
    int          busy_cnt, redir_cnt, redir_cyc;
    logic [31:0] redir_pc;
    logic [11:0] ea [4];
    logic [31:0] ev [4];

    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.trap_cause  = '0;
    bus.trap_pc     = '0;
    bus.trap_tval   = '0;
    bus.pipe_r_addr = '0;
    clear_pipe();

    vecs[0] = '{r_addr: 12'h300, w_addr: 12'h341, w_val: 32'h0000_1234, w_en: 1'b1, exp_r_val: 32'h0000_0008};
    vecs[1] = '{r_addr: 12'h341, w_addr: 12'h342, w_val: 32'h0000_0055, w_en: 1'b0, exp_r_val: 32'h0000_1234};
    vecs[2] = '{r_addr: 12'h342, w_addr: 12'h342, w_val: 32'h0000_ABCD, w_en: 1'b1, exp_r_val: 32'h0000_ABCD};
    vecs[3] = '{r_addr: 12'h342, w_addr: 12'h000, w_val: 32'h0000_0000, w_en: 1'b0, exp_r_val: 32'h0000_ABCD};
    vecs[4] = '{r_addr: 12'h305, w_addr: 12'h305, w_val: 32'hFFFF_FFFF, w_en: 1'b0, exp_r_val: 32'h0000_0101};

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_redirect_valid", 32'(bus.redirect_valid), 32'(0));
    check("rst_redirect_pc", bus.redirect_pc, 32'h0);
    check("rst_w_enable", 32'(bus.w_enable), 32'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    csr_write(12'h300, 32'h0000_0008);
    csr_write(12'h305, 32'h0000_0101);
    csr_write(12'h341, 32'h0);
    csr_write(12'h342, 32'h0);
    csr_write(12'h343, 32'h0);

    // Pass-through vectors.
    for (int i = 0; i < 5; i++) begin
      bus.pipe_r_addr   = vecs[i].r_addr;
      bus.pipe_w_addr   = vecs[i].w_addr;
      bus.pipe_w_val    = vecs[i].w_val;
      bus.pipe_w_enable = vecs[i].w_en;
      @(negedge clock);
      check($sformatf("pt%0d_csr_r_addr", i), 32'(bus.csr_r_addr), 32'(vecs[i].r_addr));
      check($sformatf("pt%0d_csr_w_addr", i), 32'(bus.csr_w_addr), 32'(vecs[i].w_addr));
      check($sformatf("pt%0d_csr_w_val", i), bus.csr_w_val, vecs[i].w_val);
      check($sformatf("pt%0d_w_enable", i), 32'(bus.w_enable), 32'(vecs[i].w_en));
      check($sformatf("pt%0d_busy", i), 32'(bus.busy), 32'(0));
      check($sformatf("pt%0d_pipe_r_val", i), bus.pipe_r_val, vecs[i].exp_r_val);
      @(posedge clock); #1;
    end
    clear_pipe();

    // Trap entry.
    csr_write(12'h300, 32'h0000_0008);
    wlog.delete();
    start_trap(32'd2, 32'h8000_0006, 32'h0000_DEAD);
    observe(8, 0, busy_cnt, redir_cnt, redir_cyc, redir_pc);
    ea = '{12'h341, 12'h342, 12'h343, 12'h300};
    ev = '{32'h8000_0004, 32'h0000_0002, 32'h0000_DEAD, 32'h0000_1880};
    check_wlog("trap", 4, ea, ev);
    check("trap_busy_cycles", 32'(busy_cnt), 32'(5));
    check("trap_redirect_count", 32'(redir_cnt), 32'(1));
    check("trap_redirect_cycle", 32'(redir_cyc), 32'(5));
    check("trap_redirect_pc", redir_pc, 32'h0000_0100);

    // Mret.
    csr_write(12'h300, 32'h0000_1880);
    csr_write(12'h341, 32'h8000_0010);
    wlog.delete();
    bus.mret_req = 1'b1;
    observe(6, 0, busy_cnt, redir_cnt, redir_cyc, redir_pc);
    ea = '{12'h300, 12'h0, 12'h0, 12'h0};
    ev = '{32'h0000_1888, 32'h0, 32'h0, 32'h0};
    check_wlog("mret", 1, ea, ev);
    check("mret_busy_cycles", 32'(busy_cnt), 32'(3));
    check("mret_redirect_count", 32'(redir_cnt), 32'(1));
    check("mret_redirect_cycle", 32'(redir_cyc), 32'(3));
    check("mret_redirect_pc", redir_pc, 32'h8000_0010);

    // Trap + mret + pipe write in one cycle: only the trap runs.
    csr_write(12'h300, 32'h8000_0002);
    csr_write(12'h305, 32'h0000_0203);
    wlog.delete();
    bus.pipe_w_addr   = 12'h340;
    bus.pipe_w_val    = 32'h0000_0077;
    bus.pipe_w_enable = 1'b1;
    bus.mret_req      = 1'b1;
    start_trap(32'h0000_000B, 32'h0000_1000, 32'h0);
    observe(10, 0, busy_cnt, redir_cnt, redir_cyc, redir_pc);
    ea = '{12'h341, 12'h342, 12'h343, 12'h300};
    ev = '{32'h0000_1000, 32'h0000_000B, 32'h0, 32'h8000_1802};
    check_wlog("simul", 4, ea, ev);
    check("simul_busy_cycles", 32'(busy_cnt), 32'(5));
    check("simul_redirect_count", 32'(redir_cnt), 32'(1));
    check("simul_redirect_pc", redir_pc, 32'h0000_0200);

    // mret pulsed during T_CAUSE is ignored.
    wlog.delete();
    start_trap(32'd4, 32'h0000_2008, 32'h0000_0044);
    observe(10, 2, busy_cnt, redir_cnt, redir_cyc, redir_pc);
    ea = '{12'h341, 12'h342, 12'h343, 12'h300};
    ev = '{32'h0000_2008, 32'h0000_0004, 32'h0000_0044, 32'h8000_1802};
    check_wlog("ign", 4, ea, ev);
    check("ign_busy_cycles", 32'(busy_cnt), 32'(5));
    check("ign_redirect_count", 32'(redir_cnt), 32'(1));
    check("ign_redirect_cycle", 32'(redir_cyc), 32'(5));
    check("ign_redirect_pc", redir_pc, 32'h0000_0200);

    // Reset asserted during T_TVAL.
    csr_write(12'h300, 32'h0000_0008);
    csr_write(12'h341, 32'h0000_0011);
    csr_write(12'h342, 32'h0000_0022);
    csr_write(12'h343, 32'h0000_0033);
    start_trap(32'd5, 32'h0000_3000, 32'h0000_0099);
    @(posedge clock); #1;
    clear_pipe();
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("pre_rst_w_enable", 32'(bus.w_enable), 32'(1));
    check("pre_rst_w_addr", 32'(bus.csr_w_addr), 32'(12'h343));
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'(0));
    check("midrst_w_enable", 32'(bus.w_enable), 32'(0));
    check("midrst_redirect_valid", 32'(bus.redirect_valid), 32'(0));
    check("midrst_redirect_pc", bus.redirect_pc, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    read_csr("midrst_mstatus", 12'h300, 32'h0000_0008);
    read_csr("midrst_mepc", 12'h341, 32'h0000_3000);
    read_csr("midrst_mcause", 12'h342, 32'h0000_0005);
    read_csr("midrst_mtval", 12'h343, 32'h0000_0033);
    bus.pipe_w_addr   = 12'h340;
    bus.pipe_w_val    = 32'h0000_0ABC;
    bus.pipe_w_enable = 1'b1;
    @(negedge clock);
    check("post_rst_busy", 32'(bus.busy), 32'(0));
    check("post_rst_w_enable", 32'(bus.w_enable), 32'(1));
    check("post_rst_w_val", bus.csr_w_val, 32'h0000_0ABC);
    @(posedge clock); #1;
    clear_pipe();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sits between the execute/commit stage and the CSR register file. It owns the regfile's single read port and single write port.
- When idle, it passes pipeline CSR accesses straight through to the regfile.
- On an exception it sequences the machine-mode trap-entry CSR updates (mepc, mcause, mtval, mstatus), then redirects fetch to mtvec.
- On mret it restores mstatus and redirects fetch to mepc. M-mode only; asynchronous interrupts are out of scope.

Parameters:
- XLEN, 32, data width of CSRs, PCs and cause.
- CSR_AW, 12, CSR address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- trap_req  in  1  exception request from commit; one-cycle pulse.
- trap_cause  in  XLEN  mcause value; bit 31 is always 0.
- trap_pc  in  XLEN  PC of the faulting instruction.
- trap_tval  in  XLEN  mtval value.
- mret_req  in  1  mret commit pulse.
- pipe_r_addr  in  CSR_AW  pipeline CSR read address.
- pipe_r_val  out  XLEN  pipeline CSR read data; always equals csr_r_val.
- pipe_w_addr  in  CSR_AW  pipeline CSR write address.
- pipe_w_val  in  XLEN  pipeline CSR write data.
- pipe_w_enable  in  1  pipeline CSR write enable.
- csr_r_addr  out  CSR_AW  to regfile.
- csr_r_val  in  XLEN  from regfile; combinational, forwards a same-cycle write.
- csr_w_addr  out  CSR_AW  to regfile.
- csr_w_val  out  XLEN  to regfile.
- w_enable  out  1  regfile write enable.
- busy  out  1  pipeline must stall and hold CSR traffic.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  XLEN  redirect target, bits [1:0] forced to 0.

Behaviour:
- Reset state:
  - State is IDLE.
  - busy, redirect_valid and w_enable are 0.
  - redirect_pc and all latches are 0.
  - Reset mid-sequence aborts immediately. No further CSR writes occur; partial updates already written remain.
- FSM states: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_JUMP, M_RD, M_WR, M_JUMP.
- IDLE:
  - csr_* ports mirror pipe_*; busy=0.
  - If trap_req=1: latch cause, pc and tval; force w_enable=0 (the faulting instruction's CSR write is dropped); go to T_EPC.
  - Else if mret_req=1: force w_enable=0; go to M_RD.
  - trap_req has priority over mret_req when both are asserted in the same cycle; the mret is discarded.
- Non-IDLE states:
  - busy=1, pipe_* inputs are ignored, and pipe_r_val still reflects csr_r_val.
  - trap_req and mret_req arriving while busy are ignored.
- Trap path:
  - T_EPC: write mepc = pc & ~3. Read mstatus and latch it as ms.
  - T_CAUSE: write mcause = cause.
  - T_TVAL: write mtval = tval.
  - T_STATUS: write mstatus = ms with MPIE(bit7)=ms.MIE(bit3), MIE=0, MPP(bits12:11)=2'b11. Read mtvec and latch it.
  - T_JUMP: w_enable=0, redirect_valid=1, redirect_pc = mtvec & ~3 (both mtvec modes use the base for exceptions). Then go to IDLE.
  - Latency: redirect_valid is asserted 5 cycles after the accept cycle. busy is high for exactly 5 cycles.
- Mret path:
  - M_RD: read mstatus and latch it as ms. No write.
  - M_WR: write mstatus = ms with MIE=ms.MPIE, MPIE=1, MPP=2'b11. Read mepc and latch it.
  - M_JUMP: redirect_valid=1, redirect_pc = mepc & ~3. Then go to IDLE.
  - Latency: busy is high for 3 cycles.
- Combinational-loop rule: the sequencer never reads and writes the same CSR address in one cycle. mstatus read-modify-write is split across states.
- No arithmetic beyond masking. All bits of mstatus other than bits 3, 7, 12:11 are preserved unchanged.

Decomposition:
- CSR address macros (mstatus, mtvec, mepc, mcause, mtval) live in def.v. Add CSR_MTVAL_ADDR there if absent.
- mstatus bit-position constants (MIE=3, MPIE=7, MPP=12:11) also go in def.v.
- The FSM state encodings are local parameters inside the module.
- No sub-module; the block is a single FSM plus pass-through mux.

Test Plan:
- Pass-through: in IDLE, pipe write 0x341 <= 0x1234 then read 0x341 -> w_enable=1 with the same address/value; pipe_r_val=0x1234 on the following cycle; busy=0.
- Trap entry: mstatus=0x00000008, mtvec=0x00000101; pulse trap_req with cause=2, pc=0x80000006, tval=0xDEAD -> writes in order:
  - mepc=0x80000004
  - mcause=2
  - mtval=0xDEAD
  - mstatus=0x00001880
  - 5 cycles after accept: redirect_valid=1, redirect_pc=0x00000100; busy high for 5 cycles.
- Mret: mstatus=0x00001880, mepc=0x80000010; pulse mret_req -> mstatus written 0x00001888; redirect_pc=0x80000010 on the 3rd cycle after accept.
- Simultaneous events: trap_req and mret_req asserted in the same cycle together with pipe_w_enable=1 -> trap sequence only; the pipe write is not issued; mret is never executed.
- Ignored requests: mret_req pulsed during T_CAUSE -> no effect; exactly one redirect occurs, to mtvec.
- Reset mid-sequence: assert reset during T_TVAL -> outputs zero immediately; mstatus unchanged; mepc/mcause keep their new values; after release the block is in IDLE pass-through.
